// File: rtl/spi_register_controller.sv
// spi_register_controller
//   Serves register-slot bytes to an SPI peripheral. DECODE maps an opcode to
//   a slot (OPCODE_BASE + i -> slot i). The slot's enable is raised and its
//   byte is held until the peripheral consumes it. After one re-arm cycle the
//   same slot is re-read. Unknown opcodes answer 'hFF with error set.
//
//   Optional feature: define SPI_REGISTER_TIMEOUT_EN to bound the wait for
//   slot data to TIMEOUT_CYCLES cycles. A timeout ends in the error state.
//
// Ports
//   clock, reset_n     : clock (rising edge), asynchronous active-low reset
//   opcode             : transaction opcode, sampled once in DECODE
//   opcode_valid       : high for the whole transaction (chip-select)
//   byte_request       : 1-cycle pulse, current response byte consumed
//   response_data      : byte returned to the peripheral
//   response_valid     : response_data is valid
//   error              : unknown opcode or timeout in this transaction
//   byte_count         : bytes consumed this transaction, saturates at 255
//   reg_enable         : one-hot slot enable
//   reg_data           : slot i byte on [8i+7:8i]
//   reg_data_valid     : slot i byte valid
module spi_register_controller #(
  parameter int unsigned N_REGS         = 4,
  parameter logic [7:0]  OPCODE_BASE    = 8'hDB,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [7:0]          opcode,
  input  logic                opcode_valid,
  input  logic                byte_request,
  output logic [7:0]          response_data,
  output logic                response_valid,
  output logic                error,
  output logic [7:0]          byte_count,
  output logic [N_REGS-1:0]   reg_enable,
  input  logic [8*N_REGS-1:0] reg_data,
  input  logic [N_REGS-1:0]   reg_data_valid
);

  localparam int unsigned IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  if (N_REGS < 1 || N_REGS > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("spi_register_controller: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WAIT,
    HOLD,
    REARM,
    ERROR
  } state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   slot, slot_next;
  logic [7:0]         data_next;
  logic               valid_next;
  logic               error_next;
  logic [7:0]         count_next;
  logic [N_REGS-1:0]  enable_next;

  logic [7:0]         decode_offset;
  logic               decode_hit;
  logic [N_REGS-1:0]  decode_onehot;
  logic [N_REGS-1:0]  slot_onehot;
  logic [7:0]         count_inc;

`ifdef SPI_REGISTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_count, wait_count_next;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      slot           <= '0;
      response_data  <= '0;
      response_valid <= 1'b0;
      error          <= 1'b0;
      byte_count     <= '0;
      reg_enable     <= '0;
`ifdef SPI_REGISTER_TIMEOUT_EN
      wait_count     <= '0;
`endif
    end else begin
      state          <= state_next;
      slot           <= slot_next;
      response_data  <= data_next;
      response_valid <= valid_next;
      error          <= error_next;
      byte_count     <= count_next;
      reg_enable     <= enable_next;
`ifdef SPI_REGISTER_TIMEOUT_EN
      wait_count     <= wait_count_next;
`endif
    end
  end

  always_comb begin
    // Modulo-256 difference: opcodes below OPCODE_BASE wrap to large offsets
    // and fall outside the slot range.
    decode_offset = opcode - OPCODE_BASE;
    decode_hit    = 32'(decode_offset) < N_REGS;
    decode_onehot = '0;
    slot_onehot   = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      decode_onehot[i] = (32'(decode_offset) == i);
      slot_onehot[i]   = (32'(slot) == i);
    end
    count_inc = (byte_count == 8'hFF) ? byte_count : byte_count + 8'd1;

    state_next  = state;
    slot_next   = slot;
    data_next   = response_data;
    valid_next  = response_valid;
    error_next  = error;
    count_next  = byte_count;
    enable_next = reg_enable;
`ifdef SPI_REGISTER_TIMEOUT_EN
    wait_count_next = wait_count;
`endif

    if (!opcode_valid) begin
      // Chip-select release wins over everything, including byte_request.
      state_next  = IDLE;
      valid_next  = 1'b0;
      error_next  = 1'b0;
      count_next  = '0;
      enable_next = '0;
    end else begin
      unique case (state)
        IDLE: state_next = DECODE;
        DECODE: begin
          if (decode_hit) begin
            slot_next   = decode_offset[IDX_W-1:0];
            enable_next = decode_onehot;
            state_next  = WAIT;
`ifdef SPI_REGISTER_TIMEOUT_EN
            wait_count_next = '0;
`endif
          end else begin
            state_next  = ERROR;
            data_next   = 8'hFF;
            valid_next  = 1'b1;
            error_next  = 1'b1;
            enable_next = '0;
          end
        end
        WAIT: begin
          if (reg_data_valid[slot]) begin
            data_next  = reg_data[{slot, 3'b000} +: 8];
            valid_next = 1'b1;
            state_next = HOLD;
          end
`ifdef SPI_REGISTER_TIMEOUT_EN
          else if (wait_count == TIMEOUT_LAST) begin
            state_next  = ERROR;
            data_next   = 8'hFF;
            valid_next  = 1'b1;
            error_next  = 1'b1;
            enable_next = '0;
          end else begin
            wait_count_next = wait_count + 16'd1;
          end
`endif
        end
        HOLD: begin
          if (byte_request) begin
            valid_next  = 1'b0;
            enable_next = '0;
            count_next  = count_inc;
            state_next  = REARM;
          end
        end
        REARM: begin
          enable_next = slot_onehot;
          state_next  = WAIT;
`ifdef SPI_REGISTER_TIMEOUT_EN
          wait_count_next = '0;
`endif
        end
        ERROR: begin
          if (byte_request) count_next = count_inc;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_register_controller.sv
// Bench for spi_register_controller (N_REGS=4, OPCODE_BASE='hDB, TIMEOUT_CYCLES=8).
// Table-driven decode vectors, directed multi-cycle sequences, then random
// stimulus compared each cycle against a transaction-level reference model.
module tb_spi_register_controller;

  localparam int N    = 4;
  localparam int BASE = 'hDB;
  localparam int TMO  = 8;
`ifdef SPI_REGISTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset_n;
  logic [7:0]   opcode;
  logic         opcode_valid;
  logic         byte_request;
  logic [7:0]   response_data;
  logic         response_valid;
  logic         error;
  logic [7:0]   byte_count;
  logic [N-1:0] reg_enable;
  logic [8*N-1:0] reg_data;
  logic [N-1:0] reg_data_valid;

  int vectors = 0;
  int miscompares = 0;

  spi_register_controller #(
    .N_REGS(N),
    .OPCODE_BASE(8'hDB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .opcode(opcode),
    .opcode_valid(opcode_valid),
    .byte_request(byte_request),
    .response_data(response_data),
    .response_valid(response_valid),
    .error(error),
    .byte_count(byte_count),
    .reg_enable(reg_enable),
    .reg_data(reg_data),
    .reg_data_valid(reg_data_valid)
  );

  always #5 clock = ~clock;

  // ---------------- reference model (transaction level) ----------------
  bit         m_busy, m_decoded, m_waiting, m_gap, m_failed;
  int         m_slot, m_waited;
  logic [7:0] m_data, m_cnt;
  logic       m_valid, m_err;
  logic [N-1:0] m_en;

  function automatic void model_reset();
    m_busy = 0; m_decoded = 0; m_waiting = 0; m_gap = 0; m_failed = 0;
    m_slot = 0; m_waited = 0;
    m_data = 8'h00; m_cnt = 8'h00; m_valid = 1'b0; m_err = 1'b0; m_en = '0;
  endfunction

  function automatic void model_fail();
    m_failed = 1; m_waiting = 0;
    m_data = 8'hFF; m_valid = 1'b1; m_err = 1'b1; m_en = '0;
  endfunction

  function automatic void model_count();
    if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
  endfunction

  // One clock edge worth of behaviour, from the inputs presented before it.
  function automatic void model_step();
    int idx;
    if (!opcode_valid) begin
      m_busy = 0; m_decoded = 0; m_waiting = 0; m_gap = 0; m_failed = 0;
      m_valid = 1'b0; m_err = 1'b0; m_cnt = 8'h00; m_en = '0;
      return;
    end
    if (!m_busy) begin
      m_busy = 1;
      return;
    end
    if (!m_decoded) begin
      m_decoded = 1;
      idx = (int'(opcode) - BASE) & 255;
      if (idx < N) begin
        m_slot = idx; m_waiting = 1; m_waited = 0; m_en = '0; m_en[idx] = 1'b1;
      end else begin
        model_fail();
      end
      return;
    end
    if (m_failed) begin
      if (byte_request) model_count();
      return;
    end
    if (m_gap) begin
      m_gap = 0; m_waiting = 1; m_waited = 0; m_en = '0; m_en[m_slot] = 1'b1;
      return;
    end
    if (m_waiting) begin
      if (reg_data_valid[m_slot]) begin
        m_data = reg_data[8*m_slot +: 8]; m_valid = 1'b1; m_waiting = 0;
      end else begin
        m_waited++;
        if (TO_EN && m_waited >= TMO) model_fail();
      end
      return;
    end
    if (byte_request) begin
      m_valid = 1'b0; m_en = '0; model_count(); m_gap = 1;
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  typedef struct {
    logic [7:0]   op;
    logic [7:0]   data;
    logic         err;
    logic [N-1:0] en;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // slot bytes: slot0='h81, slot1='h5A, slot2='hC3, slot3='h3C
    tbl[0] = '{8'hDB, 8'h81, 1'b0, 4'b0001};
    tbl[1] = '{8'hDC, 8'h5A, 1'b0, 4'b0010};
    tbl[2] = '{8'hDD, 8'hC3, 1'b0, 4'b0100};
    tbl[3] = '{8'hDE, 8'h3C, 1'b0, 4'b1000};
    tbl[4] = '{8'hDF, 8'hFF, 1'b1, 4'b0000};
    tbl[5] = '{8'hDA, 8'hFF, 1'b1, 4'b0000};
    tbl[6] = '{8'h10, 8'hFF, 1'b1, 4'b0000};
    tbl[7] = '{8'h00, 8'hFF, 1'b1, 4'b0000};

    reset_n = 1'b0; opcode = 8'h00; opcode_valid = 1'b0; byte_request = 1'b0;
    reg_data = 32'h3CC35A81; reg_data_valid = '1;
    model_reset();
    @(negedge clock); @(negedge clock);
    check("reset_data", response_data, 0);
    check("reset_valid", response_valid, 0);
    check("reset_error", error, 0);
    check("reset_count", byte_count, 0);
    check("reset_enable", reg_enable, 0);
    reset_n = 1'b1;
    tick(); tick();
    check("idle_valid", response_valid, 0);

    // decode table: response exactly on cycle 3 for good slots
    for (int i = 0; i < 8; i++) begin
      opcode_valid = 1'b0; tick();
      opcode = tbl[i].op; opcode_valid = 1'b1;
      tick(); tick();
      check($sformatf("tbl%0d_c2_valid", i), response_valid, tbl[i].err);
      tick();
      check($sformatf("tbl%0d_valid", i), response_valid, 1);
      check($sformatf("tbl%0d_data", i), response_data, tbl[i].data);
      check($sformatf("tbl%0d_error", i), error, tbl[i].err);
      check($sformatf("tbl%0d_enable", i), reg_enable, tbl[i].en);
    end

    // HOLD / REARM cycling on slot 0; opcode changes mid-transaction ignored
    opcode_valid = 1'b0; tick();
    opcode = 8'hDB; opcode_valid = 1'b1; tick(); tick(); tick();
    opcode = 8'hDD;
    for (int k = 1; k <= 3; k++) begin
      byte_request = 1'b1; tick(); byte_request = 1'b0;
      check($sformatf("rearm%0d_enable", k), reg_enable, 0);
      check($sformatf("rearm%0d_valid", k), response_valid, 0);
      check($sformatf("rearm%0d_count", k), byte_count, k);
      tick();
      check($sformatf("rewait%0d_enable", k), reg_enable, 4'b0001);
      tick();
      check($sformatf("rehold%0d_valid", k), response_valid, 1);
      check($sformatf("rehold%0d_data", k), response_data, 8'h81);
    end

    // chip-select drop together with byte_request
    byte_request = 1'b1; opcode_valid = 1'b0; tick(); byte_request = 1'b0;
    check("drop_count", byte_count, 0);
    check("drop_valid", response_valid, 0);
    check("drop_enable", reg_enable, 0);
    check("drop_error", error, 0);

    // error-state byte counting and saturation
    opcode = 8'h10; opcode_valid = 1'b1; tick(); tick();
    for (int i = 1; i <= 260; i++) begin
      byte_request = 1'b1; tick(); byte_request = 1'b0; tick();
      if (i == 254) check("sat_254", byte_count, 254);
    end
    check("sat_255", byte_count, 255);
    check("sat_data", response_data, 8'hFF);
    check("sat_error", error, 1);

    // slot never valid: timeout only with the feature built in
    opcode_valid = 1'b0; tick();
    reg_data_valid = '0; opcode = 8'hDB; opcode_valid = 1'b1;
    for (int c = 1; c <= 9; c++) tick();
    check("tmo_c9_error", error, 0);
    check("tmo_c9_enable", reg_enable, 4'b0001);
    tick();
    check("tmo_c10_error", error, TO_EN);
    check("tmo_c10_enable", reg_enable, TO_EN ? 4'b0000 : 4'b0001);
    tick(); tick();
    check("tmo_c12_error", error, TO_EN);

    // asynchronous reset in WAIT
    opcode_valid = 1'b0; tick();
    opcode_valid = 1'b1; tick(); tick();
    check("pre_rst_enable", reg_enable, 4'b0001);
    #2 reset_n = 1'b0;
    #1;
    check("arst_enable", reg_enable, 0);
    check("arst_valid", response_valid, 0);
    check("arst_data", response_data, 0);
    check("arst_error", error, 0);
    check("arst_count", byte_count, 0);
    @(negedge clock);
    opcode_valid = 1'b0; reg_data_valid = '1; reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post_rst%0d_valid", c), response_valid, 0);
    end
    opcode = 8'hDB; opcode_valid = 1'b1; tick(); tick(); tick();
    check("post_rst_new_valid", response_valid, 1);
    check("post_rst_new_data", response_data, 8'h81);

    // randomized run against the model
    @(negedge clock); reset_n = 1'b0; opcode_valid = 1'b0; byte_request = 1'b0;
    model_reset();
    @(negedge clock); reset_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (opcode_valid) opcode_valid = ($urandom_range(0, 99) < 97);
      else              opcode_valid = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) < 6) opcode = 8'(BASE + $urandom_range(0, 4));
      else                          opcode = 8'($urandom);
      byte_request = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < N; b++) reg_data_valid[b] = ($urandom_range(0, 2) == 0);
      reg_data = $urandom;
      tick();
      check("rnd_data", response_data, m_data);
      check("rnd_valid", response_valid, m_valid);
      check("rnd_error", error, m_err);
      check("rnd_count", byte_count, m_cnt);
      check("rnd_enable", reg_enable, m_en);
      check("rnd_onehot0", $onehot0(reg_enable), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_register_controller.md
SPI_REGISTER_CONTROLLER -- requirements
Module: spi_register_controller

Interface
REQ-001 Parameter N_REGS, default 4: number of register slots, 1..16.
REQ-002 Parameter OPCODE_BASE, default 'hDB: opcode of slot 0; slot i decodes OPCODE_BASE+i.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: maximum wait for slot data, 1..65535.
REQ-004 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port opcode, input, 8: transaction opcode from the SPI peripheral.
REQ-007 Port opcode_valid, input, 1: high for the whole transaction; low means chip-select released.
REQ-008 Port byte_request, input, 1: one-cycle pulse; the peripheral has consumed the current response byte.
REQ-009 Port response_data, output, 8: byte returned to the peripheral.
REQ-010 Port response_valid, output, 1: response_data is valid.
REQ-011 Port error, output, 1: current transaction has an unknown opcode or a timeout.
REQ-012 Port byte_count, output, 8: response bytes consumed in the current transaction, saturating.
REQ-013 Port reg_enable, output, N_REGS: one-hot enable to register slots.
REQ-014 Port reg_data, input, 8*N_REGS: slot i data on bits [8i+7:8i].
REQ-015 Port reg_data_valid, input, N_REGS: slot i data valid.

Function
REQ-016 States SHALL be IDLE, DECODE, WAIT, HOLD, REARM and ERROR.
REQ-017 IDLE: when opcode_valid is high, go to DECODE.
REQ-018 DECODE: if opcode-OPCODE_BASE < N_REGS, latch the slot index, assert that reg_enable bit and go to WAIT; otherwise go to ERROR.
REQ-019 WAIT: when the selected reg_data_valid is high, capture the slot byte into response_data, set response_valid the same edge and go to HOLD.
REQ-020 Latency from opcode_valid rising to response_valid SHALL be 3 cycles when the slot responds one cycle after enable.
REQ-021 HOLD: response_data and response_valid stay stable; on byte_request, clear response_valid, deassert reg_enable, increment byte_count and go to REARM.
REQ-022 REARM lasts exactly one cycle with reg_enable low, then reasserts the same one-hot bit and goes to WAIT.
REQ-023 ERROR: response_data = 'hFF, response_valid = 1, error = 1, all reg_enable bits low.
REQ-024 In ERROR, byte_request SHALL increment byte_count; response_data stays 'hFF.
REQ-025 byte_count SHALL saturate at 255 and not wrap.
REQ-026 At most one reg_enable bit is high in any cycle.
REQ-027 The opcode is sampled only in DECODE; later changes in the same transaction are ignored.
REQ-028 opcode_valid low in any state SHALL force IDLE on the next edge and clear response_valid, error, byte_count and reg_enable, taking priority over byte_request.
REQ-029 byte_request outside HOLD and ERROR is ignored.
REQ-030 reg_data_valid on unselected slots is ignored.

Reset
REQ-031 reset_n low SHALL asynchronously set IDLE and set response_data = 0, response_valid = 0, error = 0, byte_count = 0 and reg_enable = 0.
REQ-032 After release, the first transaction starts only on an opcode_valid seen high in IDLE.
REQ-033 Reset mid-transaction SHALL abandon the transaction; no stale byte is presented afterwards.

Configuration
REQ-034 Macro SPI_REGISTER_TIMEOUT_EN: when defined, a 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
REQ-035 With SPI_REGISTER_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without valid SHALL go to ERROR.
REQ-036 When SPI_REGISTER_TIMEOUT_EN is undefined, there is no counter; WAIT persists until valid arrives or opcode_valid drops, and error flags only unknown opcodes.

Verification
REQ-037 Opcode 'hDB with slot 0 returning 'h81 one cycle after enable -> response_valid at cycle 3, response_data = 'h81, error = 0, reg_enable = 4'b0001.
REQ-038 In HOLD, three byte_request pulses -> three REARM cycles with reg_enable low, byte_count = 3, and 'h81 re-presented each time.
REQ-039 Opcode 'h10 -> ERROR, response_data = 'hFF, error = 1, reg_enable = 0.
REQ-040 With SPI_REGISTER_TIMEOUT_EN and TIMEOUT_CYCLES = 8, slot never valid -> error = 1 after 8 WAIT cycles; without the macro, error stays 0.
REQ-041 opcode_valid dropped in the same cycle as byte_request in HOLD -> IDLE, byte_count = 0, response_valid = 0.
REQ-042 reset_n pulsed low in WAIT -> all outputs 0 immediately without waiting for a clock edge, and no response until a new transaction starts.
